// File: rtl/hdmi_line_fetch.sv
`timescale 1ns/1ps
// HDMI pixel prefetch: burst-reads the frame buffer into a pixel FIFO
// and pops one pixel per DE cycle toward the TMDS encoder.
module hdmi_line_fetch #(
  parameter int            HAPIX      = 1280,
  parameter int            VAPIX      = 720,
  parameter int            BURST      = 16,
  parameter int            FIFO_DEPTH = 64,
  parameter int            AW         = 22,
  parameter logic [AW-1:0] BASE_ADDR  = '0
) (
  input  logic                          clock_pixel,
  input  logic                          RESET_N,
  input  logic                          HDMI_START,
  input  logic                          FRAME_START,
  input  logic                          DE,
  output logic                          mem_req,
  output logic [AW-1:0]                 mem_addr,
  input  logic                          mem_gnt,
  input  logic                          mem_valid,
  input  logic [23:0]                   mem_data,
  output logic [7:0]                    oRed,
  output logic [7:0]                    oGreen,
  output logic [7:0]                    oBlue,
  output logic                          UNDERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int TOTAL = HAPIX * VAPIX;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LW    = PW + 1;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int BW    = $clog2(BURST + 1);

  typedef enum logic [2:0] {
    IDLE, FILL, REQ, DATA, DONE
  } state_t;

  state_t state, state_n;

  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] word_cnt;
  logic [BW-1:0] beat_cnt;
  logic [23:0]   rgb;
  logic          pending, to_idle;

  logic          stop, abort, has_room, last_beat, frame_end;
  logic          flush, restart, adv, beat_clr;
  logic          pend_set, pend_clr, wr_en, pop;
  logic [LW-1:0] free_cnt;

  assign stop      = !HDMI_START;
  assign abort     = stop || FRAME_START;
  assign free_cnt  = LW'(FIFO_DEPTH) - fifo_level;
  assign has_room  = free_cnt >= LW'(BURST);
  assign last_beat = mem_valid && (beat_cnt == BW'(BURST - 1));
  assign frame_end = word_cnt == CW'(TOTAL - BURST);

  always_comb begin
    state_n  = state;
    flush    = 1'b0;
    restart  = 1'b0;
    adv      = 1'b0;
    beat_clr = 1'b0;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    wr_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (HDMI_START && FRAME_START) begin
          flush   = 1'b1;
          restart = 1'b1;
          state_n = FILL;
        end
      end
      FILL, DONE: begin
        if (abort) begin
          flush   = 1'b1;
          restart = 1'b1;
          state_n = stop ? IDLE : FILL;
        end else if (state == FILL && has_room) begin
          state_n = REQ;
        end
      end
      REQ: begin
        // a grant coinciding with an abort still owes us a burst
        if (mem_gnt) begin
          state_n  = DATA;
          beat_clr = 1'b1;
          pend_set = abort;
        end else if (abort) begin
          flush   = 1'b1;
          restart = 1'b1;
          state_n = stop ? IDLE : FILL;
        end
      end
      DATA: begin
        pend_set = abort;
        wr_en    = mem_valid && !pending;
        if (last_beat) begin
          pend_clr = 1'b1;
          if (pending || abort) begin
            wr_en   = 1'b0;
            flush   = 1'b1;
            restart = 1'b1;
            state_n = (stop || to_idle) ? IDLE : FILL;
          end else begin
            adv     = 1'b1;
            state_n = frame_end ? DONE : FILL;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_pixel or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= BASE_ADDR;
      word_cnt <= '0;
      beat_cnt <= '0;
      pending  <= 1'b0;
      to_idle  <= 1'b0;
    end else begin
      state   <= state_n;
      mem_req <= state_n == REQ;
      if (restart) begin
        mem_addr <= BASE_ADDR;
        word_cnt <= '0;
      end else if (adv) begin
        mem_addr <= mem_addr + AW'(BURST);
        word_cnt <= word_cnt + CW'(BURST);
      end
      if (beat_clr)
        beat_cnt <= '0;
      else if (state == DATA && mem_valid)
        beat_cnt <= beat_cnt + BW'(1);
      if (pend_clr) begin
        pending <= 1'b0;
        to_idle <= 1'b0;
      end else if (pend_set) begin
        pending <= 1'b1;
        to_idle <= to_idle | stop;
      end
    end
  end

  // a flush wins over a same-cycle pop, which then sees an empty FIFO
  assign pop = DE && (fifo_level != '0) && !flush;

  always_ff @(posedge clock_pixel) begin
    if (wr_en)
      fifo_mem[wr_ptr] <= mem_data;
  end

  always_ff @(posedge clock_pixel or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      rgb        <= '0;
      UNDERFLOW  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
      end else begin
        if (wr_en)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        fifo_level <= fifo_level + LW'(wr_en) - LW'(pop);
      end
      if (DE)
        rgb <= pop ? fifo_mem[rd_ptr] : '0;
      if (DE && !pop)
        UNDERFLOW <= 1'b1;
    end
  end

  assign oRed   = rgb[23:16];
  assign oGreen = rgb[15:8];
  assign oBlue  = rgb[7:0];

endmodule

// File: tb/tb_hdmi_line_fetch.sv
`timescale 1ns/1ps
// Directed bench for hdmi_line_fetch: 32x2 frame, 16-beat bursts,
// 64-entry FIFO, with hand-derived expected addresses and pixels.
module tb_hdmi_line_fetch;

  localparam int BURST = 16;
  localparam int DEPTH = 64;

  logic        clock_pixel = 1'b0;
  logic        RESET_N     = 1'b0;
  logic        HDMI_START  = 1'b0;
  logic        FRAME_START = 1'b0;
  logic        DE          = 1'b0;
  logic        mem_gnt     = 1'b0;
  logic        mem_valid   = 1'b0;
  logic [23:0] mem_data    = '0;
  logic        mem_req;
  logic [21:0] mem_addr;
  logic [7:0]  oRed, oGreen, oBlue;
  logic        UNDERFLOW;
  logic [6:0]  fifo_level;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock_pixel = ~clock_pixel;

  hdmi_line_fetch #(
    .HAPIX(32), .VAPIX(2), .BURST(BURST),
    .FIFO_DEPTH(DEPTH), .AW(22), .BASE_ADDR(22'd0)
  ) dut (
    .clock_pixel(clock_pixel), .RESET_N(RESET_N),
    .HDMI_START(HDMI_START), .FRAME_START(FRAME_START),
    .DE(DE), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_valid(mem_valid),
    .mem_data(mem_data), .oRed(oRed), .oGreen(oGreen),
    .oBlue(oBlue), .UNDERFLOW(UNDERFLOW),
    .fifo_level(fifo_level)
  );

  function automatic logic [23:0] pix(input int a);
    return {8'(a + 17), 8'(a ^ 165), 8'(a * 3)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_pixel);
    #1;
    n_chk++;
    assert (fifo_level <= 7'(DEPTH)) else begin
      n_fail++;
      $error("FAIL level_max: observed %0d expected <= %0d",
             fifo_level, DEPTH);
    end
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!mem_req && n < budget) begin
      step();
      n++;
    end
    chk("req_seen", 32'(mem_req), 1);
  endtask

  task automatic grant(input int a);
    wait_req(40);
    chk("req_addr", 32'(mem_addr), a);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("req_drop", 32'(mem_req), 0);
  endtask

  task automatic beats(input int a, input int n);
    for (int i = 0; i < n; i++) begin
      mem_valid = 1'b1;
      mem_data  = pix(a + i);
      step();
    end
    mem_valid = 1'b0;
  endtask

  task automatic serve(input int a);
    grant(a);
    step();
    beats(a, BURST);
  endtask

  task automatic pulse_fs();
    FRAME_START = 1'b1;
    step();
    FRAME_START = 1'b0;
  endtask

  initial begin
    // reset values
    repeat (3) step();
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_rgb", {8'h0, oRed, oGreen, oBlue}, 0);
    chk("rst_under", 32'(UNDERFLOW), 0);
    chk("rst_level", 32'(fifo_level), 0);
    RESET_N    = 1'b1;
    HDMI_START = 1'b1;
    repeat (4) step();
    chk("idle_no_req", 32'(mem_req), 0);

    // fill: four bursts at 0,16,32,48 then frame complete
    pulse_fs();
    serve(0);
    chk("fill_lvl16", 32'(fifo_level), 16);
    serve(16);
    serve(32);
    serve(48);
    chk("fill_lvl64", 32'(fifo_level), 64);
    repeat (10) step();
    chk("done_no_req", 32'(mem_req), 0);
    chk("done_rgb0", {8'h0, oRed, oGreen, oBlue}, 0);

    // drain 64 pixels in address order, latency 1
    for (int i = 0; i < 64; i++) begin
      DE = 1'b1;
      step();
      chk($sformatf("pix%0d", i),
          {8'h0, oRed, oGreen, oBlue}, {8'h0, pix(i)});
      if (i == 31)
        chk("drain_lvl", 32'(fifo_level), 32);
    end
    DE = 1'b0;
    repeat (3) step();
    chk("hold_rgb", {8'h0, oRed, oGreen, oBlue}, {8'h0, pix(63)});
    chk("drain_empty", 32'(fifo_level), 0);
    chk("no_under", 32'(UNDERFLOW), 0);
    chk("done_idle_req", 32'(mem_req), 0);

    // late memory while DE runs
    pulse_fs();
    DE = 1'b1;
    step();
    chk("uf_rgb0", {8'h0, oRed, oGreen, oBlue}, 0);
    chk("uf_set", 32'(UNDERFLOW), 1);
    grant(0);
    repeat (40) step();
    chk("late_rgb0", {8'h0, oRed, oGreen, oBlue}, 0);
    DE = 1'b0;
    beats(0, BURST);
    chk("late_lvl", 32'(fifo_level), 16);
    chk("uf_sticky", 32'(UNDERFLOW), 1);
    DE = 1'b1;
    step();
    DE = 1'b0;
    chk("late_pix0", {8'h0, oRed, oGreen, oBlue}, {8'h0, pix(0)});

    // FRAME_START on beat 5: beats 6..16 dropped, then flush
    grant(16);
    step();
    for (int i = 0; i < BURST; i++) begin
      mem_valid   = 1'b1;
      mem_data    = pix(16 + i);
      FRAME_START = (i == 4);
      step();
      if (i == 10)
        chk("discard_lvl", 32'(fifo_level), 20);
    end
    mem_valid   = 1'b0;
    FRAME_START = 1'b0;
    chk("abort_flush", 32'(fifo_level), 0);
    step();
    chk("abort_req", 32'(mem_req), 1);
    chk("abort_addr", 32'(mem_addr), 0);

    // grant withheld, then FRAME_START
    serve(0);
    wait_req(10);
    chk("wh_addr", 32'(mem_addr), 16);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("wh_req", 32'(mem_req), 1);
      chk("wh_stable", 32'(mem_addr), 16);
    end
    pulse_fs();
    chk("wh_drop", 32'(mem_req), 0);
    chk("wh_flush", 32'(fifo_level), 0);
    step();
    chk("wh_rereq", 32'(mem_req), 1);
    chk("wh_base", 32'(mem_addr), 0);

    // grant withheld, then HDMI_START low
    serve(0);
    wait_req(10);
    repeat (10) step();
    chk("off_req_hi", 32'(mem_req), 1);
    HDMI_START = 1'b0;
    step();
    chk("off_drop", 32'(mem_req), 0);
    chk("off_flush", 32'(fifo_level), 0);
    HDMI_START = 1'b1;
    repeat (5) step();
    chk("off_idle", 32'(mem_req), 0);

    // asynchronous reset in the middle of a burst
    pulse_fs();
    serve(0);
    grant(16);
    step();
    beats(16, 3);
    DE = 1'b1;
    step();
    DE = 1'b0;
    chk("mid_pix", {8'h0, oRed, oGreen, oBlue}, {8'h0, pix(0)});
    chk("mid_lvl", 32'(fifo_level), 18);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 0);
    chk("arst_addr", 32'(mem_addr), 0);
    chk("arst_rgb", {8'h0, oRed, oGreen, oBlue}, 0);
    chk("arst_under", 32'(UNDERFLOW), 0);
    chk("arst_lvl", 32'(fifo_level), 0);
    step();
    RESET_N = 1'b1;
    beats(32, 5);
    chk("post_rst_lvl", 32'(fifo_level), 0);
    chk("post_rst_req", 32'(mem_req), 0);
    pulse_fs();
    wait_req(10);
    chk("post_rst_addr", 32'(mem_addr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
